// File: rtl/anthem_text_streamer.sv
// anthem_text_streamer: walks a fixed character ROM holding the anthem text
// and hands one ASCII character at a time to the display stage over a
// valid/ready interface, with a programmable gap between characters.
module anthem_text_streamer #(
  parameter int TEXT_LEN = 16,
  parameter int TICK_DIV = 4,
  parameter int LOOP     = 1,
  parameter int IDX_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [7:0]       out_char,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [IDX_W-1:0] index,
  output logic             busy
);

  localparam int PRE_W = $clog2(TICK_DIV) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TEXT_LEN - 1);
  localparam logic [PRE_W-1:0] PRE_TOP  = PRE_W'(TICK_DIV - 1);
  localparam logic             LOOP_EN  = (LOOP != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  state_t           state_r;
  logic [PRE_W-1:0] pre_r;
  // Set when a non-looping pass has finished; blocks restart until en drops.
  logic             done_r;

  // Anthem text "SOY DE ZACAPA   " as ASCII.
  function automatic logic [7:0] rom_char(input logic [IDX_W-1:0] addr);
    logic [7:0] c;
    case (addr)
      IDX_W'(0):  c = 8'h53;
      IDX_W'(1):  c = 8'h4F;
      IDX_W'(2):  c = 8'h59;
      IDX_W'(3):  c = 8'h20;
      IDX_W'(4):  c = 8'h44;
      IDX_W'(5):  c = 8'h45;
      IDX_W'(6):  c = 8'h20;
      IDX_W'(7):  c = 8'h5A;
      IDX_W'(8):  c = 8'h41;
      IDX_W'(9):  c = 8'h43;
      IDX_W'(10): c = 8'h41;
      IDX_W'(11): c = 8'h50;
      IDX_W'(12): c = 8'h41;
      IDX_W'(13): c = 8'h20;
      IDX_W'(14): c = 8'h20;
      IDX_W'(15): c = 8'h20;
      default:    c = 8'h00;
    endcase
    return c;
  endfunction

  // Streaming FSM: pacing prescaler, character presentation and handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      pre_r     <= PRE_W'(0);
      done_r    <= 1'b0;
      index     <= IDX_W'(0);
      out_char  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (en && !done_r) begin
            state_r <= ST_WAIT;
            pre_r   <= PRE_W'(0);
            busy    <= 1'b1;
          end else if (!en) begin
            done_r <= 1'b0;
          end else begin
            done_r <= done_r;
          end
        end
        ST_WAIT: begin
          if (!en) begin
            state_r <= ST_IDLE;
            pre_r   <= PRE_W'(0);
            busy    <= 1'b0;
          end else if (pre_r == PRE_TOP) begin
            state_r   <= ST_PRESENT;
            out_char  <= rom_char(index);
            out_valid <= 1'b1;
            out_last  <= (index == LAST_IDX);
          end else begin
            pre_r <= pre_r + PRE_W'(1);
          end
        end
        ST_PRESENT: begin
          // Character is held until the display stage takes it; en is ignored.
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            pre_r     <= PRE_W'(0);
            if (index == LAST_IDX) begin
              index  <= IDX_W'(0);
              done_r <= !LOOP_EN;
              if (LOOP_EN && en) begin
                state_r <= ST_WAIT;
              end else begin
                state_r <= ST_IDLE;
                busy    <= 1'b0;
              end
            end else begin
              index <= index + IDX_W'(1);
              if (en) begin
                state_r <= ST_WAIT;
              end else begin
                state_r <= ST_IDLE;
                busy    <= 1'b0;
              end
            end
          end else begin
            state_r <= ST_PRESENT;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          pre_r     <= PRE_W'(0);
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_anthem_text_streamer.sv
// Directed self-checking bench for anthem_text_streamer (looping and
// non-looping builds).
module tb_anthem_text_streamer;

  logic       clk;
  logic       rst;
  logic       en;
  logic       out_ready;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_last;
  logic [3:0] index;
  logic       busy;

  logic       en_nl;
  logic       rdy_nl;
  logic [7:0] char_nl;
  logic       valid_nl;
  logic       last_nl;
  logic [3:0] index_nl;
  logic       busy_nl;

  int checks = 0;
  int errors = 0;

  logic [7:0] rom [16] = '{8'h53, 8'h4F, 8'h59, 8'h20, 8'h44, 8'h45, 8'h20, 8'h5A,
                           8'h41, 8'h43, 8'h41, 8'h50, 8'h41, 8'h20, 8'h20, 8'h20};

  anthem_text_streamer #(.TEXT_LEN(16), .TICK_DIV(4), .LOOP(1), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .out_char(out_char), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .index(index), .busy(busy)
  );

  anthem_text_streamer #(.TEXT_LEN(16), .TICK_DIV(4), .LOOP(0), .IDX_W(4)) dut_nl (
    .clk(clk), .rst(rst), .en(en_nl), .out_char(char_nl), .out_valid(valid_nl),
    .out_ready(rdy_nl), .out_last(last_nl), .index(index_nl), .busy(busy_nl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance at least one negedge, then until out_valid or the limit.
  task automatic wait_valid(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!out_valid && cycles < limit);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; out_ready = 1'b0; en_nl = 1'b0; rdy_nl = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_char !== 8'h00 || out_last !== 1'b0 ||
        index !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b char=%h last=%b idx=%0d busy=%b, want 0 00 0 0 0",
               out_valid, out_char, out_last, index, busy);
    end
    checks++;
    if (valid_nl !== 1'b0 || index_nl !== 4'd0 || busy_nl !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_nl: got valid=%b idx=%0d busy=%b, want 0 0 0",
               valid_nl, index_nl, busy_nl);
    end
  endtask

  task automatic test_stream();
    int c;
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_valid(20, c);
      checks++;
      if (!out_valid || c != 5) begin
        errors++;
        $display("FAIL stream_timing[%0d]: got valid=%b after %0d cycles, want 1 after 5", i, out_valid, c);
      end
      checks++;
      if (out_char !== rom[i] || out_last !== (i == 15) || index !== 4'(i)) begin
        errors++;
        $display("FAIL stream_char[%0d]: got char=%h last=%b idx=%0d, want %h %b %0d",
                 i, out_char, out_last, index, rom[i], (i == 15), i);
      end
    end
    @(negedge clk);
    checks++;
    if (index !== 4'd0 || out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stream_wrap: got idx=%0d valid=%b busy=%b, want 0 0 1", index, out_valid, busy);
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || index !== 4'd0) begin
      errors++;
      $display("FAIL stream_stop: got busy=%b idx=%0d, want 0 0", busy, index);
    end
  endtask

  task automatic test_backpressure();
    int c;
    int bad;
    en = 1'b1; out_ready = 1'b0;
    wait_valid(20, c);
    checks++;
    if (!out_valid || c != 5 || out_char !== 8'h53) begin
      errors++;
      $display("FAIL bp_first: got valid=%b cycles=%0d char=%h, want 1 5 53", out_valid, c, out_char);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_char !== 8'h53 || index !== 4'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d unstable cycles, want 0", bad);
    end
    out_ready = 1'b1;
    wait_valid(20, c);
    checks++;
    if (!out_valid || c != 5 || out_char !== 8'h4F || index !== 4'd1) begin
      errors++;
      $display("FAIL bp_next: got valid=%b cycles=%0d char=%h idx=%0d, want 1 5 4f 1",
               out_valid, c, out_char, index);
    end
  endtask

  task automatic test_pause();
    int c;
    int bad;
    wait_valid(20, c);
    checks++;
    if (!out_valid || out_char !== 8'h59) begin
      errors++;
      $display("FAIL pause_third: got valid=%b char=%h, want 1 59", out_valid, out_char);
    end
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || index !== 4'd3 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pause_idle: got busy=%b idx=%0d valid=%b, want 0 3 0", busy, index, out_valid);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL pause_quiet: got %0d active cycles, want 0", bad);
    end
    en = 1'b1;
    wait_valid(20, c);
    checks++;
    if (!out_valid || c != 5 || out_char !== 8'h20 || index !== 4'd3) begin
      errors++;
      $display("FAIL pause_resume: got valid=%b cycles=%0d char=%h idx=%0d, want 1 5 20 3",
               out_valid, c, out_char, index);
    end
  endtask

  task automatic test_en_drop_present();
    int c;
    int bad;
    @(negedge clk);
    out_ready = 1'b0;
    wait_valid(20, c);
    checks++;
    if (!out_valid || c != 4 || out_char !== 8'h44 || index !== 4'd4) begin
      errors++;
      $display("FAIL drop_present: got valid=%b cycles=%0d char=%h idx=%0d, want 1 4 44 4",
               out_valid, c, out_char, index);
    end
    en = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_char !== 8'h44 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL drop_hold: got %0d dropped cycles, want 0", bad);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || index !== 4'd5) begin
      errors++;
      $display("FAIL drop_complete: got valid=%b busy=%b idx=%0d, want 0 0 5", out_valid, busy, index);
    end
  endtask

  task automatic test_async_reset();
    int c;
    en = 1'b1; out_ready = 1'b0;
    wait_valid(20, c);
    checks++;
    if (!out_valid || out_char !== 8'h45) begin
      errors++;
      $display("FAIL areset_pre: got valid=%b char=%h, want 1 45", out_valid, out_char);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || index !== 4'd0 || busy !== 1'b0 || out_char !== 8'h00) begin
      errors++;
      $display("FAIL areset_async: got valid=%b idx=%0d busy=%b char=%h, want 0 0 0 00",
               out_valid, index, busy, out_char);
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_no_loop();
    int c;
    int seen;
    en_nl = 1'b1; rdy_nl = 1'b1;
    for (int i = 0; i < 16; i++) begin
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!valid_nl && c < 20);
      checks++;
      if (!valid_nl || c != 5 || char_nl !== rom[i] || last_nl !== (i == 15)) begin
        errors++;
        $display("FAIL noloop_char[%0d]: got valid=%b cycles=%0d char=%h last=%b, want 1 5 %h %b",
                 i, valid_nl, c, char_nl, last_nl, rom[i], (i == 15));
      end
    end
    @(negedge clk);
    checks++;
    if (busy_nl !== 1'b0 || index_nl !== 4'd0 || valid_nl !== 1'b0) begin
      errors++;
      $display("FAIL noloop_end: got busy=%b idx=%0d valid=%b, want 0 0 0", busy_nl, index_nl, valid_nl);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid_nl !== 1'b0 || busy_nl !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL noloop_hold: got %0d active cycles with en held, want 0", seen);
    end
    en_nl = 1'b0;
    @(negedge clk);
    en_nl = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!valid_nl && c < 20);
    checks++;
    if (!valid_nl || c != 5 || char_nl !== 8'h53) begin
      errors++;
      $display("FAIL noloop_restart: got valid=%b cycles=%0d char=%h, want 1 5 53", valid_nl, c, char_nl);
    end
    en_nl = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_pause();
    test_en_drop_present();
    test_async_reset();
    test_no_loop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
